// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA timing-set constants, sync polarities and decode flag bundle.
// Contents:
//    SYNC_POS/SYNC_NEG          asserted sync level constants
//    VGA640_* / SVGA800_*       porch/sync/visible sizes of 640x480@60 and 800x600@72
//    vga_flags_t                per-pixel decode flags carried through the output delay
package vga_timing_pkg;
   localparam int SYNC_POS = 1;
   localparam int SYNC_NEG = 0;
   localparam int VGA640_H_VISIBLE  = 640;
   localparam int VGA640_H_FRONT    = 16;
   localparam int VGA640_H_SYNC     = 96;
   localparam int VGA640_H_BACK     = 48;
   localparam int VGA640_V_VISIBLE  = 480;
   localparam int VGA640_V_FRONT    = 10;
   localparam int VGA640_V_SYNC     = 2;
   localparam int VGA640_V_BACK     = 33;
   localparam int SVGA800_H_VISIBLE = 800;
   localparam int SVGA800_H_FRONT   = 56;
   localparam int SVGA800_H_SYNC    = 120;
   localparam int SVGA800_H_BACK    = 64;
   localparam int SVGA800_V_VISIBLE = 600;
   localparam int SVGA800_V_FRONT   = 37;
   localparam int SVGA800_V_SYNC    = 6;
   localparam int SVGA800_V_BACK    = 23;
   // Syncs are carried as "asserted" flags so an all-zero reset value means deasserted.
   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
      logic ls;
      logic fs;
      logic vb;
   } vga_flags_t;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel strobe and timing outputs between the generator and its consumer.
// Signals:
//    pix_en                         pixel strobe into the generator
//    h_pos, v_pos                   presented pixel position (CW bits)
//    hsync, vsync, active           sync levels and visible-area flag
//    line_start, frame_start, vblank_start   single pix_en-qualified strobes
// Modports: master = generator, slave = renderer / pin driver.
interface vga_timing_gen_if #(
   parameter int CW = 10
);
   logic          pix_en;
   logic [CW-1:0] h_pos;
   logic [CW-1:0] v_pos;
   logic          hsync;
   logic          vsync;
   logic          active;
   logic          line_start;
   logic          frame_start;
   logic          vblank_start;
   modport master (
      input  pix_en,
      output h_pos, v_pos, hsync, vsync, active, line_start, frame_start, vblank_start
   );
   modport slave (
      output pix_en,
      input  h_pos, v_pos, hsync, vsync, active, line_start, frame_start, vblank_start
   );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: enable-gated shift register of depth D, async active-low reset to rst_val_i.
// Ports:
//    clk, rst_n     clock and asynchronous active-low reset
//    en_i           stages advance only when high
//    rst_val_i      value loaded into every stage on reset
//    d_i / q_o      W-bit data in / data out after D enabled clocks (D=0: wire through)
module vga_delay_line #(
   parameter int W = 1,
   parameter int D = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic [W-1:0] rst_val_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   generate
      if (D == 0) begin : g_pass
         logic unused_ok;
         assign unused_ok = &{1'b0, clk, rst_n, en_i, rst_val_i};
         assign q_o = d_i;
      end else begin : g_pipe
         logic [W-1:0] sr_q [D];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < D; i++) sr_q[i] <= rst_val_i;
            end else if (en_i) begin
               sr_q[0] <= d_i;
               for (int i = 1; i < D; i++) sr_q[i] <= sr_q[i-1];
            end
         end
         assign q_o = sr_q[D-1];
      end
   endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator with pixel enable and output delay.
// Ports:
//    clk        system clock
//    sys_rst_n  asynchronous active-low reset
//    bus        vga_timing_gen_if master: pix_en in; positions, syncs, active, strobes out
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE  = VGA640_H_VISIBLE,
   parameter int H_FRONT    = VGA640_H_FRONT,
   parameter int H_SYNC     = VGA640_H_SYNC,
   parameter int H_BACK     = VGA640_H_BACK,
   parameter int V_VISIBLE  = VGA640_V_VISIBLE,
   parameter int V_FRONT    = VGA640_V_FRONT,
   parameter int V_SYNC     = VGA640_V_SYNC,
   parameter int V_BACK     = VGA640_V_BACK,
   parameter int H_SYNC_POL = SYNC_NEG,
   parameter int V_SYNC_POL = SYNC_NEG,
   parameter int CW         = 10,
   parameter int PIPE_DLY   = 0
) (
   input logic              clk,
   input logic              sys_rst_n,
   vga_timing_gen_if.master bus
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_B    = H_VISIBLE + H_FRONT;
   localparam int HS_E    = HS_B + H_SYNC;
   localparam int VS_B    = V_VISIBLE + V_FRONT;
   localparam int VS_E    = VS_B + V_SYNC;
   localparam int W       = 2 * CW + $bits(vga_flags_t);
   localparam logic HP    = H_SYNC_POL != 0;
   localparam logic VP    = V_SYNC_POL != 0;

   generate
      if (((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_cw_chk
         $error("vga_timing_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in CW bits");
      end
      if (PIPE_DLY < 0 || PIPE_DLY > 8) begin : g_dly_chk
         $error("vga_timing_gen: PIPE_DLY must be in 0..8");
      end
   endgenerate

   logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
   logic [CW-1:0] h_o, v_o;
   logic          h_last;
   vga_flags_t    fl, fl_o;

   always_comb begin
      h_last = 32'(hc_q) == H_TOTAL - 1;
      hc_d   = h_last ? '0 : hc_q + CW'(1);
      vc_d   = !h_last ? vc_q : (32'(vc_q) == V_TOTAL - 1) ? '0 : vc_q + CW'(1);
      fl.hs  = 32'(hc_q) >= HS_B && 32'(hc_q) < HS_E;
      fl.vs  = 32'(vc_q) >= VS_B && 32'(vc_q) < VS_E;
      fl.act = 32'(hc_q) < H_VISIBLE && 32'(vc_q) < V_VISIBLE;
      fl.ls  = hc_q == '0;
      fl.fs  = fl.ls && vc_q == '0;
      fl.vb  = fl.ls && 32'(vc_q) == V_VISIBLE;
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hc_q <= '0;
         vc_q <= '0;
      end else if (bus.pix_en) begin
         hc_q <= hc_d;
         vc_q <= vc_d;
      end
   end

   // All-zero reset value: positions 0, syncs deasserted, no flags.
   vga_delay_line #(.W(W), .D(PIPE_DLY)) u_dly (
      .clk       (clk),
      .rst_n     (sys_rst_n),
      .en_i      (bus.pix_en),
      .rst_val_i ('0),
      .d_i       ({hc_q, vc_q, fl}),
      .q_o       ({h_o, v_o, fl_o})
   );

   assign bus.h_pos        = h_o;
   assign bus.v_pos        = v_o;
   assign bus.hsync        = ~(fl_o.hs ^ HP);
   assign bus.vsync        = ~(fl_o.vs ^ VP);
   assign bus.active       = fl_o.act;
   // Strobes are gated so a held pixel under pix_en=0 does not repeat them.
   assign bus.line_start   = fl_o.ls & bus.pix_en;
   assign bus.frame_start  = fl_o.fs & bus.pix_en;
   assign bus.vblank_start = fl_o.vb & bus.pix_en;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of four generator configurations sharing one clock.
`define CHK(tag, o, e) chk(tag, 32'(o), 32'(e))
module tb_vga_timing_gen;
  import vga_timing_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en0 = 1'b1;
  logic en1 = 1'b1;
  int k = 0;
  int checks = 0;
  int fails = 0;
  int hs0 = 0, act0 = 0, ls0 = 0, ls1 = 0, bad1 = 0;
  always #5 clk = ~clk;
  vga_timing_gen_if #(.CW(10)) b0 ();
  vga_timing_gen_if #(.CW(10)) b1 ();
  vga_timing_gen_if #(.CW(10)) b2 ();
  vga_timing_gen_if #(.CW(4))  b3 ();
  assign b0.pix_en = en0;
  assign b1.pix_en = en1;
  assign b2.pix_en = en0;
  assign b3.pix_en = en0;
  vga_timing_gen u0 (.clk(clk), .sys_rst_n(rst_n), .bus(b0));
  vga_timing_gen u1 (.clk(clk), .sys_rst_n(rst_n), .bus(b1));
  vga_timing_gen #(.PIPE_DLY(2)) u2 (.clk(clk), .sys_rst_n(rst_n), .bus(b2));
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(SYNC_POS), .V_SYNC_POL(SYNC_POS), .CW(4)
  ) u3 (.clk(clk), .sys_rst_n(rst_n), .bus(b3));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic acc();
    if (k < 800) begin
      hs0  += int'(!b0.hsync);
      act0 += int'(b0.active);
      ls0  += int'(b0.line_start);
    end
    if (k < 1800) ls1 += int'(b1.line_start);
    if ((b1.line_start | b1.frame_start | b1.vblank_start) && !en1) bad1++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    en1 = ~en1;
    k++;
    #1;
    acc();
  endtask
  task automatic run_to(input int t);
    while (k < t) tick();
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (((b1.line_start | b1.frame_start | b1.vblank_start) & ~b1.pix_en) !== 1'b0) begin
        fails++;
        $error("FAIL u1 strobe while pix_en low at k=%0d", k);
      end
      checks++;
      if ((b0.frame_start & ~b0.line_start) !== 1'b0) begin
        fails++;
        $error("FAIL u0 frame_start without line_start at k=%0d", k);
      end
    end
  end
  initial begin
    #1;
    `CHK("rst u0 h_pos", b0.h_pos, 0);
    `CHK("rst u0 v_pos", b0.v_pos, 0);
    `CHK("rst u0 hsync", b0.hsync, 1);
    `CHK("rst u0 vsync", b0.vsync, 1);
    `CHK("rst u0 active", b0.active, 1);
    `CHK("rst u2 active", b2.active, 0);
    `CHK("rst u2 hsync", b2.hsync, 1);
    `CHK("rst u2 line_start", b2.line_start, 0);
    `CHK("rst u3 hsync", b3.hsync, 0);
    `CHK("rst u3 vsync", b3.vsync, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    acc();
    `CHK("k0 u0 frame_start", b0.frame_start, 1);
    `CHK("k0 u0 line_start", b0.line_start, 1);
    `CHK("k0 u2 frame_start", b2.frame_start, 0);
    `CHK("k0 u2 h_pos", b2.h_pos, 0);
    `CHK("k0 u3 frame_start", b3.frame_start, 1);
    `CHK("k0 u1 frame_start", b1.frame_start, 1);
    run_to(1);
    `CHK("k1 u2 frame_start", b2.frame_start, 0);
    `CHK("k1 u2 active", b2.active, 0);
    `CHK("k1 u1 h_pos", b1.h_pos, 1);
    run_to(2);
    `CHK("k2 u1 h_pos held", b1.h_pos, 1);
    `CHK("k2 u2 frame_start", b2.frame_start, 1);
    `CHK("k2 u2 active", b2.active, 1);
    `CHK("k2 u2 h_pos", b2.h_pos, 0);
    `CHK("k2 u0 h_pos", b0.h_pos, 2);
    run_to(3);
    `CHK("k3 u2 h_pos", b2.h_pos, 1);
    `CHK("k3 u1 h_pos", b1.h_pos, 2);
    run_to(7);
    `CHK("k7 u3 active", b3.active, 1);
    run_to(8);
    `CHK("k8 u3 active", b3.active, 0);
    run_to(9);
    `CHK("k9 u3 hsync", b3.hsync, 0);
    run_to(10);
    `CHK("k10 u3 hsync", b3.hsync, 1);
    run_to(11);
    `CHK("k11 u3 hsync", b3.hsync, 1);
    run_to(12);
    `CHK("k12 u3 hsync", b3.hsync, 0);
    run_to(56);
    `CHK("k56 u3 vblank_start", b3.vblank_start, 1);
    `CHK("k56 u3 v_pos", b3.v_pos, 4);
    `CHK("k56 u3 active", b3.active, 0);
    run_to(69);
    `CHK("k69 u3 vsync", b3.vsync, 0);
    run_to(70);
    `CHK("k70 u3 vsync", b3.vsync, 1);
    run_to(83);
    `CHK("k83 u3 vsync", b3.vsync, 1);
    run_to(84);
    `CHK("k84 u3 vsync", b3.vsync, 0);
    run_to(97);
    `CHK("k97 u3 h_pos", b3.h_pos, 13);
    `CHK("k97 u3 v_pos", b3.v_pos, 6);
    `CHK("k97 u3 frame_start", b3.frame_start, 0);
    run_to(98);
    `CHK("k98 u3 h_pos", b3.h_pos, 0);
    `CHK("k98 u3 v_pos", b3.v_pos, 0);
    `CHK("k98 u3 frame_start", b3.frame_start, 1);
    run_to(639);
    `CHK("k639 u0 active", b0.active, 1);
    run_to(640);
    `CHK("k640 u0 active", b0.active, 0);
    run_to(655);
    `CHK("k655 u0 hsync", b0.hsync, 1);
    run_to(656);
    `CHK("k656 u0 hsync", b0.hsync, 0);
    run_to(657);
    `CHK("k657 u2 hsync", b2.hsync, 1);
    run_to(658);
    `CHK("k658 u2 hsync", b2.hsync, 0);
    `CHK("k658 u2 h_pos", b2.h_pos, 656);
    run_to(751);
    `CHK("k751 u0 hsync", b0.hsync, 0);
    run_to(752);
    `CHK("k752 u0 hsync", b0.hsync, 1);
    run_to(753);
    `CHK("k753 u2 hsync", b2.hsync, 0);
    run_to(754);
    `CHK("k754 u2 hsync", b2.hsync, 1);
    run_to(800);
    `CHK("k800 u0 h_pos", b0.h_pos, 0);
    `CHK("k800 u0 v_pos", b0.v_pos, 1);
    `CHK("k800 u0 line_start", b0.line_start, 1);
    `CHK("k800 u0 frame_start", b0.frame_start, 0);
    `CHK("u0 hsync low count", hs0, 96);
    `CHK("u0 active count", act0, 640);
    `CHK("u0 line_start count", ls0, 1);
    run_to(1599);
    `CHK("k1599 u1 h_pos", b1.h_pos, 0);
    `CHK("k1599 u1 line_start", b1.line_start, 0);
    run_to(1600);
    `CHK("k1600 u1 line_start", b1.line_start, 1);
    `CHK("k1600 u1 v_pos", b1.v_pos, 1);
    run_to(1601);
    `CHK("k1601 u1 h_pos", b1.h_pos, 1);
    run_to(1900);
    `CHK("u1 line_start count", ls1, 2);
    `CHK("u1 strobe without pix_en", bad1, 0);
    `CHK("k1900 u0 h_pos", b0.h_pos, 300);
    `CHK("k1900 u0 v_pos", b0.v_pos, 2);
    #1;
    rst_n = 1'b0;
    #1;
    `CHK("async u0 h_pos", b0.h_pos, 0);
    `CHK("async u0 v_pos", b0.v_pos, 0);
    `CHK("async u2 h_pos", b2.h_pos, 0);
    `CHK("async u2 active", b2.active, 0);
    `CHK("async u3 h_pos", b3.h_pos, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    en1 = 1'b1;
    k = 0;
    #2;
    `CHK("rel u0 frame_start", b0.frame_start, 1);
    `CHK("rel u2 frame_start", b2.frame_start, 0);
    run_to(2);
    `CHK("rel u0 h_pos", b0.h_pos, 2);
    `CHK("rel u0 v_pos", b0.v_pos, 0);
    `CHK("rel u2 frame_start k2", b2.frame_start, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
